// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - push-button synchroniser, debouncer, press detector and DAS/ARR auto-repeat
//
// Purpose:
//   Conditions the five board push-buttons for the game logic. Each channel is
//   synchronised (2 flops), debounced, edge-detected and, on movement keys,
//   auto-repeated (DAS delay, then ARR period). Every press/repeat event is
//   stretched to PULSE_LEN cycles so a slower game clock can sample it.
//
// Ports:
//   CLK100MHZ  in   1  system clock
//   rst        in   1  synchronous, active-high reset
//   btn_raw    in   5  asynchronous buttons [0]=left [1]=right [2]=up [3]=down [4]=center
//   key_level  out  5  debounced button state
//   key_pulse  out  5  stretched press/repeat pulse per channel
//   any_press  out  1  single-cycle OR of all key_level rising edges (registered)
module input_conditioner #(
  parameter int         DEBOUNCE_CYC = 1_000_000,
  parameter int         DAS_CYC      = 17_000_000,
  parameter int         ARR_CYC      = 5_000_000,
  parameter int         PULSE_LEN    = 4,
  parameter logic [4:0] REPEAT_MASK  = 5'b01011
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [4:0] key_level,
  output logic [4:0] key_pulse,
  output logic       any_press
);

  localparam int TMAX = (DAS_CYC > ARR_CYC) ? DAS_CYC : ARR_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int SW   = $clog2(PULSE_LEN + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] DAS_LAST = TW'(DAS_CYC - 1);
  localparam logic [TW-1:0] ARR_LAST = TW'(ARR_CYC - 1);
  localparam logic [SW-1:0] PULSE_LD = SW'(PULSE_LEN);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } ch_state_t;

  logic [4:0] sync_q1;
  logic [4:0] sync_q2;
  logic [4:0] stable;
  logic [4:0] stable_d;
  logic [4:0] rise;

  // Shared front end: synchroniser, edge-detect delay and the any_press register.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sync_q1   <= '0;
      sync_q2   <= '0;
      stable_d  <= '0;
      any_press <= 1'b0;
    end else begin
      sync_q1   <= btn_raw;
      sync_q2   <= sync_q1;
      stable_d  <= stable;
      any_press <= |rise;
    end
  end

  assign rise      = stable & ~stable_d;
  assign key_level = stable;

  for (genvar ch = 0; ch < 5; ch++) begin : g_ch
    logic            stable_q;
    logic [DW-1:0]   db_cnt;
    ch_state_t       state_q;
    ch_state_t       state_d;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;
    logic            fire_c;
    logic [SW-1:0]   stretch_cnt;

    // Debounce: the synchronised input must disagree with the accepted state
    // for DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
    always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
        stable_q <= 1'b0;
        db_cnt   <= '0;
      end else if (sync_q2[ch] == stable_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable_q <= sync_q2[ch];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end

    assign stable[ch] = stable_q;

    always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
        state_q <= IDLE;
        timer_q <= '0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
      end
    end

    // Auto-repeat FSM. A release seen in the same cycle as a terminal count
    // wins, so no pulse is emitted for a key that is already up.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      fire_c  = 1'b0;
      if (REPEAT_MASK[ch]) begin
        case (state_q)
          IDLE: begin
            if (rise[ch]) begin
              fire_c  = 1'b1;
              state_d = DELAY;
              timer_d = '0;
            end
          end
          DELAY: begin
            if (!stable_q) begin
              state_d = IDLE;
              timer_d = '0;
            end else if (timer_q == DAS_LAST) begin
              fire_c  = 1'b1;
              state_d = REPEAT;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
          REPEAT: begin
            if (!stable_q) begin
              state_d = IDLE;
              timer_d = '0;
            end else if (timer_q == ARR_LAST) begin
              fire_c  = 1'b1;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
          default: begin
            state_d = IDLE;
            timer_d = '0;
          end
        endcase
      end else begin
        fire_c = rise[ch];
      end
    end

    // Stretcher: a fire reloads the count, so overlapping events merge into
    // one continuous pulse instead of producing a fresh edge.
    always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
        stretch_cnt <= '0;
      end else if (fire_c) begin
        stretch_cnt <= PULSE_LD;
      end else if (stretch_cnt != '0) begin
        stretch_cnt <= stretch_cnt - SW'(1);
      end
    end

    assign key_pulse[ch] = (stretch_cnt != '0);
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner against a behavioural model
module tb_input_conditioner;

  localparam int         DB   = 8;
  localparam int         DAS  = 40;
  localparam int         ARR  = 10;
  localparam int         PL   = 4;
  localparam logic [4:0] RMSK = 5'b01011;

  logic       clk;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] key_level;
  logic [4:0] key_pulse;
  logic       any_press;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  input_conditioner #(
    .DEBOUNCE_CYC(DB),
    .DAS_CYC     (DAS),
    .ARR_CYC     (ARR),
    .PULSE_LEN   (PL),
    .REPEAT_MASK (RMSK)
  ) dut (
    .CLK100MHZ(clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .key_level(key_level),
    .key_pulse(key_pulse),
    .any_press(any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: time-stamped events instead of counters/FSM.
  //   sync      = raw delayed by two edges
  //   stable    flips once sync has held the other value for DB consecutive edges
  //   fires     at press edge t0, then t0+DAS, t0+DAS+k*ARR while held (repeat keys)
  //   key_pulse high while the latest fire is less than PL edges old
  logic [4:0] m_s1, m_s2, m_stable, m_stable_d, m_prev_sync, m_active;
  int         m_run [5];
  int         m_t0  [5];
  int         m_lf  [5];
  logic [4:0] m_level, m_pulse;
  logic       m_anyp;
  logic [4:0] rise_v;
  logic       r, f, o_sync, o_st, o_std;
  int         d;

  initial begin
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_d = '0; m_prev_sync = '0; m_active = '0;
    m_level = '0; m_pulse = '0; m_anyp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_run[i] = 0; m_t0[i] = 0; m_lf[i] = -1000;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_d = '0; m_prev_sync = '0; m_active = '0;
      m_anyp = 1'b0;
      for (int i = 0; i < 5; i++) begin
        m_run[i] = 0; m_lf[i] = -1000;
      end
    end else begin
      rise_v = '0;
      for (int ch = 0; ch < 5; ch++) begin
        o_sync = m_s2[ch];
        o_st   = m_stable[ch];
        o_std  = m_stable_d[ch];
        r      = o_st & ~o_std;
        rise_v[ch] = r;
        f = 1'b0;
        if (r) begin
          f = 1'b1;
          m_active[ch] = RMSK[ch];
          m_t0[ch] = cyc;
        end else if (m_active[ch]) begin
          if (!o_st) begin
            m_active[ch] = 1'b0;
          end else begin
            d = cyc - m_t0[ch];
            if (d == DAS || (d > DAS && ((d - DAS) % ARR) == 0)) f = 1'b1;
          end
        end
        if (f) m_lf[ch] = cyc;
        if (o_sync == m_prev_sync[ch]) begin
          if (m_run[ch] < 1000) m_run[ch] = m_run[ch] + 1;
        end else begin
          m_run[ch] = 1;
        end
        m_prev_sync[ch] = o_sync;
        if (o_sync != o_st && m_run[ch] >= DB) m_stable[ch] = o_sync;
        m_stable_d[ch] = o_st;
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = btn_raw[ch];
      end
      m_anyp = |rise_v;
    end
    for (int ch = 0; ch < 5; ch++) m_pulse[ch] = ((cyc - m_lf[ch]) < PL);
    m_level = m_stable;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Continuous comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin
    chk("key_level", 32'(key_level), 32'(m_level));
    chk("key_pulse", 32'(key_pulse), 32'(m_pulse));
    chk("any_press", 32'(any_press), 32'(m_anyp));
  end

  task automatic goto(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic idle(input int n);
    btn_raw = '0;
    repeat (n) @(negedge clk);
  endtask

  int base, base2, e;
  logic seen;
  int rate;
  int rep_edges [6] = '{11, 51, 61, 71, 81, 91};

  initial begin
    rst = 1'b1;
    btn_raw = '0;
    repeat (3) @(negedge clk);
    chk("reset_level", 32'(key_level), 32'd0);
    chk("reset_pulse", 32'(key_pulse), 32'd0);
    chk("reset_any",   32'(any_press), 32'd0);
    rst = 1'b0;
    idle(5);

    // Clean press on a non-repeat key.
    base = cyc;
    btn_raw[2] = 1'b1;
    goto(base + 9);  chk("t1_level9",  32'(key_level[2]), 32'd0);
    goto(base + 10); chk("t1_level10", 32'(key_level[2]), 32'd1);
                     chk("t1_model_level10", 32'(m_level[2]), 32'd1);
                     chk("t1_pulse10", 32'(key_pulse[2]), 32'd0);
    goto(base + 11); chk("t1_pulse11", 32'(key_pulse[2]), 32'd1);
                     chk("t1_any11",   32'(any_press), 32'd1);
                     chk("t1_model_any11", 32'(m_anyp), 32'd1);
    goto(base + 12); chk("t1_any12",   32'(any_press), 32'd0);
    goto(base + 14); chk("t1_pulse14", 32'(key_pulse[2]), 32'd1);
    goto(base + 15); chk("t1_pulse15", 32'(key_pulse[2]), 32'd0);
                     chk("t1_model_pulse15", 32'(m_pulse[2]), 32'd0);
    goto(base + 51); chk("t1_norepeat51", 32'(key_pulse[2]), 32'd0);
    goto(base + 100);
    idle(30);

    // Held repeat key: DAS then ARR pulses.
    base = cyc;
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = base + rep_edges[i];
      goto(e - 1); chk("t2_before", 32'(key_pulse[0]), 32'd0);
      goto(e);     chk("t2_rise",   32'(key_pulse[0]), 32'd1);
                   chk("t2_model_rise", 32'(m_pulse[0]), 32'd1);
      goto(e + 3); chk("t2_last",   32'(key_pulse[0]), 32'd1);
      goto(e + 4); chk("t2_after",  32'(key_pulse[0]), 32'd0);
    end
    goto(base + 100);
    idle(30);

    // Glitch and bounce train on key 3 must be rejected.
    base = cyc;
    btn_raw[3] = 1'b1;
    goto(base + 5);  btn_raw[3] = 1'b0;
    goto(base + 8);  btn_raw[3] = 1'b1;
    goto(base + 11); btn_raw[3] = 1'b0;
    goto(base + 14); btn_raw[3] = 1'b1;
    goto(base + 17); btn_raw[3] = 1'b0;
    seen = 1'b0;
    while (cyc < base + 45) begin
      @(negedge clk);
      seen = seen | key_level[3] | key_pulse[3];
    end
    chk("t3_glitch_rejected", 32'(seen), 32'd0);
    idle(10);

    // Release during DELAY, then a fresh press restarts DAS.
    base = cyc;
    btn_raw[0] = 1'b1;
    goto(base + 30); btn_raw[0] = 1'b0;
    goto(base + 39); chk("t4_level39", 32'(key_level[0]), 32'd1);
    goto(base + 40); chk("t4_level40", 32'(key_level[0]), 32'd0);
    goto(base + 51); chk("t4_no_das",  32'(key_pulse[0]), 32'd0);
    goto(base + 60);
    base2 = cyc;
    btn_raw[0] = 1'b1;
    goto(base2 + 11); chk("t4_fresh11", 32'(key_pulse[0]), 32'd1);
    goto(base2 + 50); chk("t4_fresh50", 32'(key_pulse[0]), 32'd0);
    goto(base2 + 51); chk("t4_fresh51", 32'(key_pulse[0]), 32'd1);
    goto(base2 + 55);
    idle(30);

    // All five keys on the same edge.
    base = cyc;
    btn_raw = 5'h1f;
    goto(base + 9);  chk("t5_level9",  32'(key_level), 32'h00);
    goto(base + 10); chk("t5_level10", 32'(key_level), 32'h1f);
    goto(base + 11); chk("t5_pulse11", 32'(key_pulse), 32'h1f);
                     chk("t5_any11",   32'(any_press), 32'd1);
    goto(base + 12); chk("t5_any12",   32'(any_press), 32'd0);
    goto(base + 14); chk("t5_pulse14", 32'(key_pulse), 32'h1f);
    goto(base + 15); chk("t5_pulse15", 32'(key_pulse), 32'h00);
    goto(base + 30);
    idle(30);

    // Reset while key 1 is auto-repeating.
    base = cyc;
    btn_raw[1] = 1'b1;
    goto(base + 59); rst = 1'b1;
    goto(base + 61); chk("t6_rst_level", 32'(key_level), 32'd0);
                     chk("t6_rst_pulse", 32'(key_pulse), 32'd0);
                     chk("t6_rst_any",   32'(any_press), 32'd0);
    goto(base + 62); rst = 1'b0;
    goto(base + 71); chk("t6_level71", 32'(key_level[1]), 32'd0);
    goto(base + 72); chk("t6_level72", 32'(key_level[1]), 32'd1);
    goto(base + 73); chk("t6_pulse73", 32'(key_pulse[1]), 32'd1);
                     chk("t6_any73",   32'(any_press), 32'd1);
    goto(base + 80);
    idle(30);

    // Randomised phases alternating bouncy and calm toggling, with rare resets.
    rate = 60;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ((i % 200) == 0) rate = ($urandom_range(0, 1) == 1) ? 4 : 60;
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, rate - 1) == 0) btn_raw[b] = ~btn_raw[b];
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
